// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared register-file widths and the LSU writeback entry type.
package soc_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int WB_ENTRY_W = REG_ADDR_W + XLEN;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    typedef struct packed {
        reg_addr_t rd;
        xlen_t     wd;
    } wb_entry_t;

    // One-hot register mask; x0 never produces a bit so sb[0] stays 0.
    function automatic logic [NUM_REGS-1:0] reg_mask(input reg_addr_t idx, input logic en);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (en && idx != '0) begin
            m[idx] = 1'b1;
        end
        return m;
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback, LSU, decode and register-file port bundle.
interface regfile_wb_arbiter_if;
    import soc_pkg::*;

    logic      pipe_we;
    reg_addr_t pipe_rd;
    xlen_t     pipe_wd;
    logic      lsu_issue;
    reg_addr_t lsu_issue_rd;
    logic      lsu_wb_valid;
    logic      lsu_wb_ready;
    reg_addr_t lsu_wb_rd;
    xlen_t     lsu_wb_wd;
    reg_addr_t dec_rs1;
    reg_addr_t dec_rs2;
    reg_addr_t dec_rd;
    logic      stall;
    logic      rf_we;
    reg_addr_t rf_rd;
    xlen_t     rf_wd;
    logic      sb_busy;
    logic      err;

    modport master (
        output pipe_we, pipe_rd, pipe_wd,
        output lsu_issue, lsu_issue_rd,
        output lsu_wb_valid, lsu_wb_rd, lsu_wb_wd,
        output dec_rs1, dec_rs2, dec_rd,
        input  lsu_wb_ready, stall, rf_we, rf_rd, rf_wd, sb_busy, err
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_wd,
        input  lsu_issue, lsu_issue_rd,
        input  lsu_wb_valid, lsu_wb_rd, lsu_wb_wd,
        input  dec_rs1, dec_rs2, dec_rd,
        output lsu_wb_ready, stall, rf_we, rf_rd, rf_wd, sb_busy, err
    );
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular sync FIFO buffering LSU completions.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with LSU scoreboard.
module regfile_wb_arbiter
    import soc_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    logic [NUM_REGS-1:0]   sb;
    logic [NUM_REGS-1:0]   set_mask;
    logic [NUM_REGS-1:0]   clr_mask;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [WB_ENTRY_W-1:0] fifo_rdata;
    wb_entry_t             head;
    wb_entry_t             push_entry;
    logic                  pipe_wins;
    logic                  lsu_writes;
    logic                  issue_conflict;
    logic                  orphan_wb;
    logic                  overflow;
    logic                  err_q;
    logic                  rf_we_q;
    reg_addr_t             rf_rd_q;
    xlen_t                 rf_wd_q;

    assign push_entry = '{rd: bus.lsu_wb_rd, wd: bus.lsu_wb_wd};
    assign head       = wb_entry_t'(fifo_rdata);

    assign bus.lsu_wb_ready = !fifo_full;
    assign fifo_push        = bus.lsu_wb_valid && !fifo_full;

    // Pipeline has fixed priority; a write to x0 leaves the port free for the FIFO.
    assign pipe_wins  = bus.pipe_we && (bus.pipe_rd != '0);
    assign fifo_pop   = !pipe_wins && !fifo_empty;
    assign lsu_writes = fifo_pop && (head.rd != '0);

    assign set_mask = reg_mask(bus.lsu_issue_rd, bus.lsu_issue);
    assign clr_mask = reg_mask(head.rd, fifo_pop);

    // Re-issue to a register whose pending write retires this same cycle is legitimate.
    assign issue_conflict = |(set_mask & sb & ~clr_mask);
    assign orphan_wb      = fifo_push && (bus.lsu_wb_rd != '0) && !sb[bus.lsu_wb_rd];
    assign overflow       = bus.lsu_wb_valid && fifo_full;

    assign bus.stall   = sb[bus.dec_rs1] | sb[bus.dec_rs2] | sb[bus.dec_rd];
    assign bus.sb_busy = |sb;
    assign bus.err     = err_q;
    assign bus.rf_we   = rf_we_q;
    assign bus.rf_rd   = rf_rd_q;
    assign bus.rf_wd   = rf_wd_q;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WB_ENTRY_W)
    ) u_wb_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb      <= '0;
            err_q   <= 1'b0;
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_wd_q <= '0;
        end else begin
            // Set after clear so a same-cycle re-issue keeps the bit.
            sb <= (sb & ~clr_mask) | set_mask;
            if (issue_conflict || orphan_wb || overflow) begin
                err_q <= 1'b1;
            end
            rf_we_q <= pipe_wins || lsu_writes;
            if (pipe_wins) begin
                rf_rd_q <= bus.pipe_rd;
                rf_wd_q <= bus.pipe_wd;
            end else if (lsu_writes) begin
                rf_rd_q <= head.rd;
                rf_wd_q <= head.wd;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pwe;
        logic [4:0]  prd;
        logic [31:0] pwd;
        logic        iss;
        logic [4:0]  ird;
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wwd;
        logic [4:0]  d1;
        logic [4:0]  d2;
        logic [4:0]  dd;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic        e_stall;
        logic        e_ready;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.pipe_we      = 1'b0;
        bus.pipe_rd      = '0;
        bus.pipe_wd      = '0;
        bus.lsu_issue    = 1'b0;
        bus.lsu_issue_rd = '0;
        bus.lsu_wb_valid = 1'b0;
        bus.lsu_wb_rd    = '0;
        bus.lsu_wb_wd    = '0;
        bus.dec_rs1      = '0;
        bus.dec_rs2      = '0;
        bus.dec_rd       = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        bus.pipe_we      = v.pwe;
        bus.pipe_rd      = v.prd;
        bus.pipe_wd      = v.pwd;
        bus.lsu_issue    = v.iss;
        bus.lsu_issue_rd = v.ird;
        bus.lsu_wb_valid = v.wv;
        bus.lsu_wb_rd    = v.wrd;
        bus.lsu_wb_wd    = v.wwd;
        bus.dec_rs1      = v.d1;
        bus.dec_rs2      = v.d2;
        bus.dec_rd       = v.dd;
        tick();
    endtask

    task automatic pipe_busy(input logic [31:0] wd);
        bus.pipe_we = 1'b1;
        bus.pipe_rd = 5'd1;
        bus.pipe_wd = wd;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        //             pwe   prd    pwd            iss   ird    wv    wrd    wwd            d1     d2     dd     e_we  e_rd   e_wd           stall ready busy  err
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd7,  32'h1234,     5'd7,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  5'd0,  1'b1, 5'd7,  32'h1234,     1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd9,  1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 5'd3,  32'h33,       1'b0, 5'd0,  1'b1, 5'd9,  32'h99,       5'd0,  5'd0,  5'd9,  1'b1, 5'd3,  32'h33,       1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 5'd3,  32'h34,       1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd9,  1'b1, 5'd3,  32'h34,       1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 5'd3,  32'h35,       1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd9,  1'b1, 5'd3,  32'h35,       1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd9,  1'b1, 5'd9,  32'h99,       1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd11, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 5'd0,  32'hFFFF,     1'b0, 5'd0,  1'b1, 5'd11, 32'hB,        5'd0,  5'd0,  5'd11, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 5'd0,  32'hEEEE,     1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd11, 1'b1, 5'd11, 32'hB,        1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd0,  32'h77,       5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        check("reset rf_we", {31'd0, bus.rf_we}, 32'd0);
        check("reset rf_rd", {27'd0, bus.rf_rd}, 32'd0);
        check("reset rf_wd", bus.rf_wd, 32'd0);
        check("reset ready", {31'd0, bus.lsu_wb_ready}, 32'd1);
        check("reset stall", {31'd0, bus.stall}, 32'd0);
        check("reset busy", {31'd0, bus.sb_busy}, 32'd0);
        check("reset err", {31'd0, bus.err}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
            check($sformatf("v%0d rf_we", i), {31'd0, bus.rf_we}, {31'd0, vecs[i].e_we});
            if (vecs[i].e_we) begin
                check($sformatf("v%0d rf_rd", i), {27'd0, bus.rf_rd}, {27'd0, vecs[i].e_rd});
                check($sformatf("v%0d rf_wd", i), bus.rf_wd, vecs[i].e_wd);
            end
            check($sformatf("v%0d stall", i), {31'd0, bus.stall}, {31'd0, vecs[i].e_stall});
            check($sformatf("v%0d ready", i), {31'd0, bus.lsu_wb_ready}, {31'd0, vecs[i].e_ready});
            check($sformatf("v%0d busy", i), {31'd0, bus.sb_busy}, {31'd0, vecs[i].e_busy});
            check($sformatf("v%0d err", i), {31'd0, bus.err}, {31'd0, vecs[i].e_err});
        end

        // FIFO fill under pipeline starvation, overflow error, drain.
        do_reset();
        pipe_busy(32'h100); bus.lsu_issue = 1'b1; bus.lsu_issue_rd = 5'd4; tick();
        pipe_busy(32'h101); bus.lsu_issue_rd = 5'd5; tick();
        pipe_busy(32'h102); bus.lsu_issue_rd = 5'd6; tick();
        bus.lsu_issue = 1'b0;
        pipe_busy(32'h103); bus.lsu_wb_valid = 1'b1; bus.lsu_wb_rd = 5'd4; bus.lsu_wb_wd = 32'h44; tick();
        check("fill1 ready", {31'd0, bus.lsu_wb_ready}, 32'd1);
        pipe_busy(32'h104); bus.lsu_wb_rd = 5'd5; bus.lsu_wb_wd = 32'h55; tick();
        check("full ready", {31'd0, bus.lsu_wb_ready}, 32'd0);
        check("full err", {31'd0, bus.err}, 32'd0);
        check("full rf_wd", bus.rf_wd, 32'h104);
        pipe_busy(32'h105); bus.lsu_wb_rd = 5'd6; bus.lsu_wb_wd = 32'h66; tick();
        check("overflow err", {31'd0, bus.err}, 32'd1);
        check("overflow ready", {31'd0, bus.lsu_wb_ready}, 32'd0);
        clear_inputs(); tick();
        check("drain1 rf_rd", {27'd0, bus.rf_rd}, 32'd4);
        check("drain1 rf_wd", bus.rf_wd, 32'h44);
        check("drain1 ready", {31'd0, bus.lsu_wb_ready}, 32'd1);
        tick();
        check("drain2 rf_we", {31'd0, bus.rf_we}, 32'd1);
        check("drain2 rf_rd", {27'd0, bus.rf_rd}, 32'd5);
        check("drain2 busy", {31'd0, bus.sb_busy}, 32'd1);

        // Re-issue to a register in the cycle its pending write retires.
        do_reset();
        bus.dec_rs2 = 5'd8;
        bus.lsu_issue = 1'b1; bus.lsu_issue_rd = 5'd8; tick();
        bus.lsu_issue = 1'b0; bus.lsu_wb_valid = 1'b1; bus.lsu_wb_rd = 5'd8; bus.lsu_wb_wd = 32'h88; tick();
        bus.lsu_wb_valid = 1'b0; bus.lsu_issue = 1'b1; tick();
        check("reissue rf_we", {31'd0, bus.rf_we}, 32'd1);
        check("reissue rf_rd", {27'd0, bus.rf_rd}, 32'd8);
        check("reissue stall", {31'd0, bus.stall}, 32'd1);
        bus.lsu_issue = 1'b0; tick();
        check("reissue stall hold", {31'd0, bus.stall}, 32'd1);
        bus.lsu_wb_valid = 1'b1; bus.lsu_wb_wd = 32'h89; tick();
        bus.lsu_wb_valid = 1'b0; tick();
        check("reissue2 rf_wd", bus.rf_wd, 32'h89);
        check("reissue2 stall", {31'd0, bus.stall}, 32'd0);
        check("reissue2 busy", {31'd0, bus.sb_busy}, 32'd0);

        // Completion for a never-issued register.
        do_reset();
        bus.lsu_wb_valid = 1'b1; bus.lsu_wb_rd = 5'd10; bus.lsu_wb_wd = 32'hA; tick();
        check("orphan err", {31'd0, bus.err}, 32'd1);
        bus.lsu_wb_valid = 1'b0; tick();
        check("orphan rf_we", {31'd0, bus.rf_we}, 32'd1);
        check("orphan rf_rd", {27'd0, bus.rf_rd}, 32'd10);
        check("orphan err sticky", {31'd0, bus.err}, 32'd1);

        // Asynchronous reset with queued entries and pending bits.
        do_reset();
        bus.dec_rs1 = 5'd14;
        pipe_busy(32'h200); bus.lsu_issue = 1'b1; bus.lsu_issue_rd = 5'd12; tick();
        pipe_busy(32'h201); bus.lsu_issue_rd = 5'd13; tick();
        pipe_busy(32'h202); bus.lsu_issue_rd = 5'd14; bus.lsu_wb_valid = 1'b1; bus.lsu_wb_rd = 5'd12; bus.lsu_wb_wd = 32'hC; tick();
        pipe_busy(32'h203); bus.lsu_issue = 1'b0; bus.lsu_wb_rd = 5'd13; bus.lsu_wb_wd = 32'hD; tick();
        check("prerst ready", {31'd0, bus.lsu_wb_ready}, 32'd0);
        check("prerst stall", {31'd0, bus.stall}, 32'd1);
        rst_n = 1'b0;
        #2;
        check("async rf_we", {31'd0, bus.rf_we}, 32'd0);
        check("async rf_rd", {27'd0, bus.rf_rd}, 32'd0);
        check("async rf_wd", bus.rf_wd, 32'd0);
        check("async ready", {31'd0, bus.lsu_wb_ready}, 32'd1);
        check("async stall", {31'd0, bus.stall}, 32'd0);
        check("async busy", {31'd0, bus.sb_busy}, 32'd0);
        check("async err", {31'd0, bus.err}, 32'd0);
        clear_inputs();
        bus.dec_rs1 = 5'd14;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("postrst%0d rf_we", c), {31'd0, bus.rf_we}, 32'd0);
            check($sformatf("postrst%0d stall", c), {31'd0, bus.stall}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
